mem_delayed_pipe: RTL and testbench
===================================

MEM_DELAYED_PIPE -- requirements
Module: mem_delayed_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, data word width in bits (power of two, >= 8).
REQ-002 SHALL have parameter ADDR_WIDTH, 32, byte address width.
REQ-003 SHALL have parameter DEPTH_WORDS, 4096, number of memory words.
REQ-004 SHALL have parameter LATENCY, 5, enabled cycles from request acceptance to response (>= 1).
REQ-005 SHALL have parameter MAX_OUTSTANDING, 4, request queue depth (>= 1).
REQ-006 SHALL have port clk  input  1  clock, rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port ena  input  1  countdown enable; requests still queue while low.
REQ-009 SHALL have ports req_valid, req_we  input  1  request strobe; 1 = write, 0 = read.
REQ-010 SHALL have ports req_addr  input  ADDR_WIDTH and req_wdata  input  DATA_WIDTH  byte address, write data.
REQ-011 SHALL have port req_ready  output  1  queue can accept a request.
REQ-012 SHALL have ports rsp_valid, rsp_err  output  1  one-cycle completion pulse; out-of-range flag.
REQ-013 SHALL have port rsp_rdata  output  DATA_WIDTH  read data, valid only with rsp_valid.
REQ-014 SHALL have port busy  output  1  at least one request outstanding.
REQ-015 SHALL have ports oob_wen  input  1, oob_addr  input  ADDR_WIDTH, oob_wdata  input  DATA_WIDTH  out-of-band byte-addressed loader write.

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; req_ready SHALL be 1 iff outstanding count < MAX_OUTSTANDING (registered state only, no combinational dependence on req_valid).
REQ-017 Each accepted request SHALL capture we, addr, wdata and a countdown of LATENCY-1 into the queue tail.
REQ-018 All queued countdowns above 0 SHALL decrement by 1 on each edge where ena=1; they SHALL hold while ena=0.
REQ-019 The head entry SHALL retire on an edge where ena=1 and its countdown is 0; at most one retire per edge; responses strictly in acceptance order.
REQ-020 With ena held high, a request accepted at edge k SHALL produce rsp_valid=1 for exactly the cycle following edge k+LATENCY.
REQ-021 Word index SHALL be addr >> log2(DATA_WIDTH/8); low address bits ignored.
REQ-022 Read retire SHALL register rsp_rdata = mem[index]; write retire SHALL commit wdata to mem[index] on that edge with rsp_rdata = 0.
REQ-023 Index >= DEPTH_WORDS SHALL give rsp_err=1, rsp_rdata=0, and drop the write; otherwise rsp_err=0.
REQ-024 rsp_rdata and rsp_err SHALL be 0 in every cycle where rsp_valid=0.
REQ-025 Accept and retire on the same edge SHALL leave the count unchanged; a full queue SHALL deassert req_ready until a retire.
REQ-026 A read retiring after an earlier-accepted write to the same word SHALL return the written data.
REQ-027 oob_wen=1 SHALL write oob_wdata to mem[oob_addr index] on that edge regardless of ena; on collision with a write retire to the same word, the retire SHALL win.
REQ-028 busy SHALL equal (outstanding count != 0), registered.

Reset
REQ-029 rst=1 SHALL immediately clear the queue and count and drive req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0.
REQ-030 Requests outstanding at reset SHALL be discarded with no response and no memory write; memory contents SHALL not be reset.

Configuration
REQ-031 With MEM_DELAYED_PIPE_WSTRB_EN defined, the block SHALL add input req_wstrb of width DATA_WIDTH/8, captured with the request, and a write retire SHALL update only bytes whose strobe bit is 1.
REQ-032 Without MEM_DELAYED_PIPE_WSTRB_EN, req_wstrb SHALL not exist and every write SHALL update the full word.

Verification
REQ-033 LATENCY=5, ena=1: oob-load mem word 3 = 0x1234; read addr 12 at edge 0 -> rsp_valid only in cycle after edge 5, rsp_rdata=0x1234.
REQ-034 MAX_OUTSTANDING=4: four back-to-back reads -> req_ready=0 after the fourth accept, four in-order responses on consecutive cycles, req_ready=1 after the first retire.
REQ-035 Write 0xDEADBEEF to addr 8 then read addr 8 next cycle -> read response 0xDEADBEEF one cycle after the write response.
REQ-036 ena=0 for 10 cycles after a read accept, then ena=1 -> response exactly LATENCY enabled edges after accept; busy=1 throughout.
REQ-037 Read addr 4*DEPTH_WORDS -> rsp_valid=1, rsp_err=1, rsp_rdata=0; rst asserted with 2 reads pending -> no response, busy=0, req_ready=1.
REQ-038 With MEM_DELAYED_PIPE_WSTRB_EN: word = 0xFFFFFFFF, write 0x00000000 with strobe 4'b0101 -> readback 0xFF00FF00.

Source files
------------

// File: rtl/mem_delayed_pipe.sv
// mem_delayed_pipe
//   Word-addressed memory behind a fixed-latency request queue. Every accepted
//   request waits LATENCY enabled clock edges, then retires in acceptance order
//   and produces a one-cycle response pulse. An out-of-band port lets a loader
//   write the memory directly at any time.
//
//   Optional build macro: MEM_DELAYED_PIPE_WSTRB_EN adds a per-byte write strobe
//   input (req_wstrb). Without it every write updates the full word.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   ena                      countdown enable; requests still queue while low
//   req_valid/req_we         request strobe and direction (1 = write)
//   req_addr/req_wdata       byte address and write data
//   req_wstrb                byte strobes (only with MEM_DELAYED_PIPE_WSTRB_EN)
//   req_ready                queue has room
//   rsp_valid/rsp_err        completion pulse and out-of-range flag
//   rsp_rdata                read data (zero unless a read response)
//   busy                     at least one request outstanding
//   oob_wen/oob_addr/oob_wdata  loader write, byte addressed

module mem_delayed_pipe #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int DEPTH_WORDS     = 4096,
    parameter int LATENCY         = 5,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    req_valid,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
`ifdef MEM_DELAYED_PIPE_WSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
`endif
    output logic                    req_ready,
    output logic                    rsp_valid,
    output logic                    rsp_err,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    busy,
    input  logic                    oob_wen,
    input  logic [ADDR_WIDTH-1:0]   oob_addr,
    input  logic [DATA_WIDTH-1:0]   oob_wdata
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(NB);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW    = $clog2(LATENCY + 1);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [NB-1:0]         strb;
        logic [CW-1:0]         cd;
    } entry_t;

    // Queue is a shift register: slot 0 is always the head, slot cnt_q-1 the tail.
    entry_t             q_q [MAX_OUTSTANDING];
    entry_t             q_d [MAX_OUTSTANDING];
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic               busy_q, busy_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    entry_t              head, new_entry;
    logic [ADDR_WIDTH-1:0] head_idx, oob_idx;
    logic                head_in, oob_in;
    logic                accept, retire, mem_we;
    logic [CNT_W-1:0]    tail;

    assign head     = q_q[0];
    assign head_idx = head.addr >> OFFS;
    assign oob_idx  = oob_addr >> OFFS;
    assign head_in  = head_idx < ADDR_WIDTH'(DEPTH_WORDS);
    assign oob_in   = oob_idx < ADDR_WIDTH'(DEPTH_WORDS);

    assign req_ready = cnt_q < CNT_W'(MAX_OUTSTANDING);
    assign accept    = req_valid && req_ready;
    assign retire    = ena && (cnt_q != '0) && (head.cd == '0);
    assign mem_we    = retire && head.we && head_in;

    always_comb begin
        new_entry       = '0;
        new_entry.we    = req_we;
        new_entry.addr  = req_addr;
        new_entry.wdata = req_wdata;
`ifdef MEM_DELAYED_PIPE_WSTRB_EN
        new_entry.strb  = req_wstrb;
`else
        new_entry.strb  = '1;
`endif
        new_entry.cd    = CW'(LATENCY - 1);
    end

    always_comb begin
        q_d = q_q;
        // Every live entry counts down, not only the head, so back-to-back
        // requests retire on consecutive edges.
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (ena && (CNT_W'(i) < cnt_q) && (q_q[i].cd != '0))
                q_d[i].cd = q_q[i].cd - 1'b1;
        end
        if (retire) begin
            for (int i = 0; i < MAX_OUTSTANDING - 1; i++)
                q_d[i] = q_d[i + 1];
            q_d[MAX_OUTSTANDING - 1] = '0;
        end
        tail = retire ? cnt_q - 1'b1 : cnt_q;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (accept && (CNT_W'(i) == tail))
                q_d[i] = new_entry;
        end

        cnt_d = cnt_q;
        if (accept && !retire)
            cnt_d = cnt_q + 1'b1;
        else if (!accept && retire)
            cnt_d = cnt_q - 1'b1;

        rsp_valid_d = retire;
        rsp_err_d   = retire && !head_in;
        rsp_rdata_d = '0;
        if (retire && !head.we && head_in)
            rsp_rdata_d = mem[head_idx[IDX_W-1:0]];
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++)
                q_q[i] <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
        end
    end

    // Memory is never reset. The retire write is issued after the loader
    // write so it takes precedence on a same-word collision.
    always_ff @(posedge clk) begin
        if (oob_wen && oob_in)
            mem[oob_idx[IDX_W-1:0]] <= oob_wdata;
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (head.strb[b])
                    mem[head_idx[IDX_W-1:0]][b*8 +: 8] <= head.wdata[b*8 +: 8];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_delayed_pipe.sv
// Scoreboard bench for mem_delayed_pipe: issue() pushes the expected response
// (edge number, err, data) and a negedge monitor pops and compares.
module tb_mem_delayed_pipe;
    localparam int DW = 32, AW = 32, DEPTH = 4096, LAT = 5, MAXO = 4;

    logic clk = 1'b0, rst = 1'b1, ena = 1'b1;
    logic req_valid = 1'b0, req_we = 1'b0;
    logic [AW-1:0] req_addr = '0, oob_addr = '0;
    logic [DW-1:0] req_wdata = '0, oob_wdata = '0;
    logic oob_wen = 1'b0;
`ifdef MEM_DELAYED_PIPE_WSTRB_EN
    logic [DW/8-1:0] req_wstrb = '1;
`endif
    logic req_ready, rsp_valid, rsp_err, busy;
    logic [DW-1:0] rsp_rdata;

    mem_delayed_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH),
                       .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEM_DELAYED_PIPE_WSTRB_EN
        .req_wstrb(req_wstrb),
`endif
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .busy(busy),
        .oob_wen(oob_wen), .oob_addr(oob_addr), .oob_wdata(oob_wdata));

    typedef struct { int edge_no; logic err; logic [31:0] data; } exp_t;
    exp_t sb[$];
    int errors = 0, checks = 0, edge_n = 0, last_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: got rdata %h err %b expected none (edge %0d)",
                             rsp_rdata, rsp_err, edge_n);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_edge", edge_n, e.edge_no);
                    chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                    chk("rsp_rdata", rsp_rdata, e.data);
                end
            end else begin
                chk("idle_rdata", rsp_rdata, 32'h0);
                chk("idle_err", {31'b0, rsp_err}, 32'h0);
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic eerr, input logic [31:0] edata, input int extra);
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 100) begin
            req_valid = 1'b0; t++; @(negedge clk);
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: got req_ready 0 expected 1");
        end else begin
            req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
            last_acc = edge_n + 1;
            sb.push_back('{last_acc + LAT + extra, eerr, edata});
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 200) begin
            t++; @(negedge clk);
        end
        if (sb.size() != 0 || busy) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic oob(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        oob_wen = 1'b1; oob_addr = addr; oob_wdata = data;
        @(negedge clk);
        oob_wen = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        rst = 1'b0;

        // Basic latency: loader word 3, read byte address 12, then an unaligned alias.
        oob(32'd12, 32'h0000_1234);
        issue(1'b0, 32'd12, 32'h0, 1'b0, 32'h0000_1234, 0);
        idle();
        drain();
        issue(1'b0, 32'd15, 32'h0, 1'b0, 32'h0000_1234, 0);
        idle();
        drain();

        // Four back-to-back reads fill the queue.
        for (int i = 0; i < 4; i++) oob(32'(40 + 4 * i), 32'hA0 + 32'(i));
        for (int i = 0; i < 4; i++)
            issue(1'b0, 32'(40 + 4 * i), 32'h0, 1'b0, 32'hA0 + 32'(i), 0);
        idle();
        chk("full_ready", {31'b0, req_ready}, 32'h0);
        chk("full_busy", {31'b0, busy}, 32'h1);
        @(negedge clk);
        chk("full_ready_hold", {31'b0, req_ready}, 32'h0);
        @(negedge clk);
        chk("ready_after_retire", {31'b0, req_ready}, 32'h1);
        drain();

        // Write then read same word on the next cycle.
        issue(1'b1, 32'd8, 32'hDEAD_BEEF, 1'b0, 32'h0, 0);
        issue(1'b0, 32'd8, 32'h0, 1'b0, 32'hDEAD_BEEF, 0);
        idle();
        drain();

        // ena low for 10 edges after accept stretches the response by 10.
        issue(1'b0, 32'd8, 32'h0, 1'b0, 32'hDEAD_BEEF, 10);
        @(negedge clk);
        req_valid = 1'b0; ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("ena_low_busy", {31'b0, busy}, 32'h1);
        end
        ena = 1'b1;
        drain();

        // Loader write colliding with a retiring write: the retire wins.
        issue(1'b1, 32'd16, 32'hAAAA_5555, 1'b0, 32'h0, 0);
        idle();
        repeat (LAT - 1) @(negedge clk);
        oob_wen = 1'b1; oob_addr = 32'd16; oob_wdata = 32'h0BAD_0BAD;
        @(negedge clk);
        oob_wen = 1'b0;
        drain();
        issue(1'b0, 32'd16, 32'h0, 1'b0, 32'hAAAA_5555, 0);
        idle();
        drain();

        // Out-of-range read and write; the write must not alias onto word 1.
        oob(32'd4, 32'h1111_1111);
        issue(1'b0, 32'(4 * DEPTH), 32'h0, 1'b1, 32'h0, 0);
        issue(1'b1, 32'(4 * DEPTH + 4), 32'h5A5A_5A5A, 1'b1, 32'h0, 0);
        issue(1'b0, 32'd4, 32'h0, 1'b0, 32'h1111_1111, 0);
        idle();
        drain();

`ifdef MEM_DELAYED_PIPE_WSTRB_EN
        oob(32'd20, 32'hFFFF_FFFF);
        req_wstrb = 4'b0101;
        issue(1'b1, 32'd20, 32'h0, 1'b0, 32'h0, 0);
        idle();
        req_wstrb = '1;
        drain();
        issue(1'b0, 32'd20, 32'h0, 1'b0, 32'hFF00_FF00, 0);
        idle();
        drain();
`endif

        // Reset with two reads pending: no responses, queue empty.
        issue(1'b0, 32'd12, 32'h0, 1'b0, 32'h0, 0);
        issue(1'b0, 32'd12, 32'h0, 1'b0, 32'h0, 0);
        idle();
        sb.delete();
        rst = 1'b1;
        #1;
        chk("rst_pend_busy", {31'b0, busy}, 32'h0);
        chk("rst_pend_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_pend_valid", {31'b0, rsp_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_rst_busy", {31'b0, busy}, 32'h0);

        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL sb_leftover: got %0d expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
